// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer_pkg: shared FSM state type and mode encodings for the counter sequencer.
package counter_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/counter_sequencer_prescaler.sv
// counter_sequencer_prescaler: PRE_W-bit divider that strobes step when it reaches the prescale value.
module counter_sequencer_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             step
);
    localparam logic [PRE_W-1:0] ONE = 1;
    logic [PRE_W-1:0] pre;
    assign step = en && !clr && (pre == prescale);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre <= '0;
        else if (clr || step) pre <= '0;
        else if (en) pre <= pre + ONE;
    end
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: programmable timer sequencing a shared up-counter with a one-cycle wrap tick.
// Define COUNTER_SEQUENCER_STATUS_EN to add the saturating wrap_count status register and status_clr.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic             cfg_periodic,
    input  logic             start,
    input  logic             stop,
`ifdef COUNTER_SEQUENCER_STATUS_EN
    input  logic             status_clr,
    output logic [7:0]       wrap_count,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);
    localparam logic [WIDTH-1:0] ONE = 1;
    state_t           state;
    logic [WIDTH-1:0] limit;
    logic [PRE_W-1:0] prescale;
    logic             periodic;
    logic             step;
    logic             wrap;

    counter_sequencer_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk      (CLK),
        .rst      (RESET),
        .en       (state == RUN),
        .clr      (stop || state != RUN),
        .prescale (prescale),
        .step     (step)
    );

    assign wrap = step && (count == limit);

    // stop outranks both start and a wrap landing on the same edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            count     <= '0;
            tick      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
            limit     <= '1;
            prescale  <= '0;
            periodic  <= MODE_ONESHOT;
        end else begin
            tick <= 1'b0;
            if (cfg_valid && cfg_ready) begin
                limit    <= cfg_limit;
                prescale <= cfg_prescale;
                periodic <= cfg_periodic;
            end
            if (stop) begin
                state     <= IDLE;
                count     <= '0;
                busy      <= 1'b0;
                done      <= 1'b0;
                cfg_ready <= 1'b1;
            end else if (state == RUN) begin
                if (step) count <= wrap ? '0 : count + ONE;
                if (wrap) begin
                    tick <= 1'b1;
                    if (periodic != MODE_PERIODIC) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cfg_ready <= 1'b1;
                    end
                end
            end else if (start) begin
                state     <= RUN;
                count     <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
                cfg_ready <= 1'b0;
            end
        end
    end

`ifdef COUNTER_SEQUENCER_STATUS_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) wrap_count <= '0;
        else if (status_clr) wrap_count <= '0;
        else if (wrap && wrap_count != 8'hFF) wrap_count <= wrap_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed stimulus with an elapsed-cycle arithmetic model checked every cycle.
module tb_counter_sequencer;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_periodic = 1'b0;
    logic [3:0] cfg_limit = '0;
    logic [3:0] cfg_prescale = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cfg_ready, busy, tick, done;
    logic [3:0] count;
`ifdef COUNTER_SEQUENCER_STATUS_EN
    logic       status_clr = 1'b0;
    logic [7:0] wrap_count;
`endif

    counter_sequencer #(.WIDTH(4), .PRE_W(4)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_limit    (cfg_limit),
        .cfg_prescale (cfg_prescale),
        .cfg_periodic (cfg_periodic),
        .start        (start),
        .stop         (stop),
`ifdef COUNTER_SEQUENCER_STATUS_EN
        .status_clr   (status_clr),
        .wrap_count   (wrap_count),
`endif
        .count        (count),
        .busy         (busy),
        .tick         (tick),
        .done         (done)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_n counts edges since RUN entry; outputs follow from division by the period.
    int m_st, m_n, m_L, m_P, m_per, m_wc;
    bit m_tick;
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_st = 0; m_n = 0; m_L = 15; m_P = 0; m_per = 0; m_tick = 0; m_wc = 0;
        end else begin
            m_tick = 0;
            if (cfg_valid && m_st != 1) begin
                m_L = cfg_limit; m_P = cfg_prescale; m_per = cfg_periodic;
            end
            if (stop) m_st = 0;
            else if (m_st == 1) begin
                m_n++;
                if (m_n % ((m_L + 1) * (m_P + 1)) == 0) begin
                    m_tick = 1;
                    if (m_per == 0) m_st = 2;
                end
            end else if (start) begin
                m_st = 1; m_n = 0;
            end
`ifdef COUNTER_SEQUENCER_STATUS_EN
            if (status_clr) m_wc = 0;
            else if (m_tick && m_wc < 255) m_wc++;
`endif
        end
    end

    always @(negedge CLK) begin
        if (!RESET) begin
            chk("count", count, (m_st == 1) ? (m_n / (m_P + 1)) % (m_L + 1) : 0);
            chk("tick", tick, m_tick);
            chk("busy", busy, m_st == 1);
            chk("done", done, m_st == 2);
            chk("cfg_ready", cfg_ready, m_st != 1);
`ifdef COUNTER_SEQUENCER_STATUS_EN
            chk("wrap_count", wrap_count, m_wc);
`endif
        end
    end

    task automatic cfg(input int l, input int p, input bit per);
        cfg_valid = 1; cfg_limit = 4'(l); cfg_prescale = 4'(p); cfg_periodic = per;
        @(negedge CLK);
        cfg_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge CLK);
        start = 0;
    endtask

    task automatic pulse_stop();
        stop = 1;
        @(negedge CLK);
        stop = 0;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        RESET = 0;
        @(negedge CLK);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cfg_ready, 1);

        // periodic, limit 3: 0,1,2,3,0 with tick on the wrap
        cfg(3, 0, 1);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            chk("per_count", count, i % 4);
            chk("per_tick", tick, i == 4);
            chk("per_busy", busy, 1);
            if (i < 4) @(negedge CLK);
        end
        repeat (6) @(negedge CLK);
        pulse_stop();

        // one-shot, limit 2, prescale 2: tick 9 cycles after entry
        cfg(2, 2, 0);
        pulse_start();
        repeat (8) @(negedge CLK);
        chk("os_pre_count", count, 2);
        chk("os_pre_tick", tick, 0);
        @(negedge CLK);
        chk("os_tick", tick, 1);
        chk("os_done", done, 1);
        chk("os_count", count, 0);
        chk("os_ready", cfg_ready, 1);
        @(negedge CLK);
        chk("os_tick_once", tick, 0);
        chk("os_done_hold", done, 1);

        // stop on the exact would-be wrap edge
        cfg(1, 1, 1);
        pulse_start();
        repeat (3) @(negedge CLK);
        chk("sw_at_limit", count, 1);
        pulse_stop();
        chk("sw_count", count, 0);
        chk("sw_tick", tick, 0);
        chk("sw_busy", busy, 0);

        // start and stop together while DONE
        cfg(0, 0, 0);
        pulse_start();
        @(negedge CLK);
        chk("d_done", done, 1);
        start = 1; stop = 1;
        @(negedge CLK);
        start = 0; stop = 0;
        chk("ss_done", done, 0);
        chk("ss_busy", busy, 0);
        @(negedge CLK);
        chk("ss_idle", busy, 0);

        // config offered during RUN is refused; old limit stays
        cfg(3, 0, 1);
        pulse_start();
        @(negedge CLK);
        cfg_valid = 1; cfg_limit = 7;
        chk("run_ready", cfg_ready, 0);
        @(negedge CLK);
        cfg_valid = 0;
        @(negedge CLK);
        chk("run_old_lim", count, 3);
        @(negedge CLK);
        chk("run_old_tick", tick, 1);
        pulse_stop();

        // config accepted together with start
        cfg_valid = 1; cfg_limit = 5; cfg_prescale = 0; cfg_periodic = 1; start = 1;
        @(negedge CLK);
        cfg_valid = 0; start = 0;
        repeat (5) @(negedge CLK);
        chk("new_lim_count", count, 5);
        chk("new_lim_notick", tick, 0);
        @(negedge CLK);
        chk("new_lim_tick", tick, 1);
        chk("new_lim_wrap", count, 0);

        // asynchronous reset in the middle of a cycle
        repeat (2) @(negedge CLK);
        #2 RESET = 1;
        #1;
        chk("ar_count", count, 0);
        chk("ar_busy", busy, 0);
        chk("ar_tick", tick, 0);
        chk("ar_ready", cfg_ready, 1);
        @(negedge CLK);
        RESET = 0;
        @(negedge CLK);

        // reset config: limit 15, one-shot
        pulse_start();
        repeat (15) @(negedge CLK);
        chk("rc_count", count, 15);
        @(negedge CLK);
        chk("rc_tick", tick, 1);
        chk("rc_done", done, 1);
        repeat (2) @(negedge CLK);

`ifdef COUNTER_SEQUENCER_STATUS_EN
        cfg(0, 0, 1);
        pulse_start();
        repeat (300) @(negedge CLK);
        chk("wc_sat", wrap_count, 255);
        status_clr = 1;
        @(negedge CLK);
        status_clr = 0;
        chk("wc_clr", wrap_count, 0);
        @(negedge CLK);
        pulse_stop();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Control block that sequences a shared up-counter datapath (adder + register) as a programmable timer. It accepts a configuration (terminal value, prescale, mode) over a valid/ready handshake, then runs the counter on start, halts it on stop, and reports each terminal-count wrap with a one-cycle tick. It sits above the counter/register primitives and is the single owner of their enable, clear and load controls.

Parameters:
WIDTH, 4, width of the main count and the terminal-value register
PRE_W, 4, width of the prescale divider and its configuration field

Ports:
CLK  input  1  single clock; all state updates on rising edge
RESET  input  1  asynchronous, active-high reset; clears all state immediately
cfg_valid  input  1  configuration offered this cycle
cfg_ready  output  1  configuration accepted when cfg_valid && cfg_ready
cfg_limit  input  WIDTH  terminal value; count wraps after reaching it
cfg_prescale  input  PRE_W  count advances once every cfg_prescale+1 cycles
cfg_periodic  input  1  1 = periodic (auto-restart); 0 = one-shot
start  input  1  begin or restart a run (level sampled each cycle)
stop  input  1  abort a run and return to IDLE
count  output  WIDTH  current count value (registered)
busy  output  1  high while in RUN
tick  output  1  one-cycle pulse in the cycle after a terminal-count wrap
done  output  1  high while in DONE (one-shot completed)

Behaviour:
- Reset values: state=IDLE, count=0, prescale counter=0, tick=0, done=0, busy=0, cfg_ready=1. Config registers reset to limit=all-ones, prescale=0, periodic=0.
- FSM states: IDLE, RUN, DONE.
- cfg_ready=1 in IDLE and DONE, 0 in RUN. An accepted config is registered on that edge.
- If a config is accepted in the same cycle as start, the run uses the new config.
- IDLE: start -> RUN; count<=0 and pre<=0 on that edge.
- RUN, on every edge:
  - If pre != cfg_prescale: pre<=pre+1; count holds.
  - Else pre<=0, and a step occurs:
    - If count != limit: count<=count+1.
    - Else count<=0 and tick<=1 for exactly one cycle; state stays RUN if periodic, otherwise goes to DONE.
- RUN + stop -> IDLE; count<=0, pre<=0, no tick, even if a wrap would have occurred on that edge.
- stop and start in the same cycle: stop wins in every state. In IDLE/DONE, stop also clears done and returns to IDLE.
- DONE: done=1, count=0. start -> RUN (done falls on that edge). start is ignored while in RUN.
- Period in periodic mode is exactly (limit+1)*(prescale+1) cycles. limit=0, prescale=0 gives tick high every cycle after the first RUN cycle. Increments wrap modulo 2^WIDTH only through the limit compare, never by overflow.
- RESET asserted mid-run aborts immediately to reset values. No tick is emitted.
- Count sequence with prescale=0, limit=3: after the start edge, count = 0,1,2,3,0(tick),1,...

Optional Feature:
COUNTER_SEQUENCER_STATUS_EN
- Defined: adds input status_clr (1) and output wrap_count (8). wrap_count is a saturating (stops at 255) count of ticks since reset or since the last status_clr.
  - status_clr takes priority over an increment in the same cycle.
  - Reset value is 0.
- Undefined: neither port exists and there is no added logic. Core behaviour is identical in both builds.

Decomposition:
- Package counter_sequencer_pkg: state enum type (IDLE, RUN, DONE) and mode constants MODE_ONESHOT=0, MODE_PERIODIC=1.
- Sub-module counter_sequencer_prescaler: holds the PRE_W-bit divider with enable and clear. It produces a one-cycle step strobe when pre==cfg_prescale.
- FSM, config registers and the main count stay in the top module.

Test Plan:
- Reset: assert RESET asynchronously mid-cycle -> count=0, tick=0, busy=0, done=0, cfg_ready=1 before the next edge.
- Periodic run: cfg limit=3, prescale=0, periodic=1, then pulse start -> count 0,1,2,3,0; tick high every 4th cycle; busy stays 1.
- Prescaled one-shot: limit=2, prescale=2, periodic=0 -> count advances every 3 cycles; single tick 9 cycles after RUN entry; then DONE with done=1, count=0, cfg_ready=1.
- Stop during a would-be wrap cycle (count=limit, pre=prescale) -> IDLE, count=0, no tick; start and stop together in DONE -> IDLE.
- Config handshake: cfg_valid in RUN -> cfg_ready=0 and old limit kept; cfg_valid+start in the same cycle in IDLE -> the run uses the new limit=5 (tick after count 5).
- With COUNTER_SEQUENCER_STATUS_EN: 300 ticks at limit=0 -> wrap_count=255; status_clr -> 0.
